program_counter_stack: RTL and testbench
========================================

PROGRAM_COUNTER_STACK -- requirements
Module: program_counter_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, address/counter width in bits (>=2).
REQ-002 SHALL have parameter DEPTH, default 4, return-stack entries (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port load  input  1  absolute jump request.
REQ-006 SHALL have port load_value  input  WIDTH  jump/call target.
REQ-007 SHALL have port call  input  1  push return address, jump to load_value.
REQ-008 SHALL have port ret  input  1  pop return address into counter.
REQ-009 SHALL have port rel  input  1  relative branch request.
REQ-010 SHALL have port offset  input  WIDTH  two's-complement branch offset.
REQ-011 SHALL have port inc  input  1  increment request.
REQ-012 SHALL have port dec  input  1  decrement request.
REQ-013 SHALL have port out  output  WIDTH  current counter value, registered.
REQ-014 SHALL have port depth  output  $clog2(DEPTH+1)  valid stack entries.
REQ-015 SHALL have ports stack_full, stack_empty  output  1 each  depth==DEPTH, depth==0; combinational from depth.
REQ-016 SHALL have ports ovf, unf  output  1 each  sticky overflow / underflow error flags.

Function
REQ-017 SHALL act on at most one request per cycle, priority load > call > ret > rel > dec > inc; lower-priority requests that cycle are ignored.
REQ-018 load: out <= load_value next cycle; stack untouched.
REQ-019 call, not full: stack[depth] <= out+1 (mod 2^WIDTH), depth+1, out <= load_value, single cycle.
REQ-020 call when full: out, stack, depth unchanged; ovf <= 1.
REQ-021 ret, not empty: out <= stack[depth-1], depth-1, single cycle.
REQ-022 ret when empty: out, depth unchanged; unf <= 1.
REQ-023 rel: out <= out + offset, modulo 2^WIDTH (offset sign-interpreted, result truncated).
REQ-024 dec: out <= out-1; 0 wraps to 2^WIDTH-1.
REQ-025 inc: out <= out+1; 2^WIDTH-1 wraps to 0.
REQ-026 No request asserted: all state holds.
REQ-027 ovf/unf, once set, SHALL remain 1 until reset; they do not block further operation.
REQ-028 Stack SHALL be LIFO; entries at index >= depth are don't-care and never observable on out.

Reset
REQ-029 reset_n low SHALL immediately (no clock) force out=0, depth=0, ovf=0, unf=0; stack_empty=1, stack_full=0.
REQ-030 Reset asserted mid-sequence (e.g. during nested calls) SHALL discard all stack contents; first cycle after release behaves as from empty.
REQ-031 Stack storage need not be reset.

Configuration
REQ-032 Macro PC_REL_BRANCH_EN SHALL gate the relative branch.
REQ-033 Defined: rel/offset behave per REQ-023 at the stated priority.
REQ-034 Undefined: rel and offset ignored (no state change from them); ports remain present; dec/inc still act when rel is high alone with them.

Verification
REQ-035 Reset, then inc x3 -> out=3; dec x4 -> out=255 (WIDTH=8).
REQ-036 load_value=0x40 with load+call+inc same cycle -> out=0x40, depth=0 (load wins, no push).
REQ-037 out=0x10; call 0x80, call 0x90 -> depth=2, out=0x90; ret -> out=0x81; ret -> out=0x11, stack_empty=1.
REQ-038 DEPTH=4: five calls -> depth=4, stack_full=1, ovf=1, out=4th target; ret on empty after 4 rets -> unf=1, out unchanged.
REQ-039 PC_REL_BRANCH_EN defined: out=0x05, rel offset=0xFA -> out=0xFF; undefined: same stimulus with inc -> out=0x06.
REQ-040 After two calls, pulse reset_n low between edges -> out=0, depth=0 immediately; ret next -> unf=1.

Source files
------------

// File: rtl/program_counter_stack.sv
// Program counter with a LIFO return-address stack, sticky overflow/underflow flags.
// Optional feature: define PC_REL_BRANCH_EN to enable the rel/offset relative branch.
module program_counter_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load,
    input  logic [WIDTH-1:0]           load_value,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       rel,
    input  logic [WIDTH-1:0]           offset,
    input  logic                       inc,
    input  logic                       dec,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf,
    output logic                       unf
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0]    DepthOne = DW'(1);
    localparam logic [DW-1:0]    DepthMax = DW'(DEPTH);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [WIDTH-1:0] r_out;
    logic [DW-1:0]    r_depth;
    logic             r_ovf;
    logic             r_unf;
    // Sized to the full index range of r_depth so every index is in bounds.
    logic [WIDTH-1:0] r_stack [0:(1<<DW)-1];

    logic [WIDTH-1:0] w_out_nxt;
    logic [DW-1:0]    w_depth_nxt;
    logic             w_ovf_nxt;
    logic             w_unf_nxt;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_rel_req;

`ifdef PC_REL_BRANCH_EN
    assign w_rel_req = rel;
`else
    logic w_unused;
    assign w_rel_req = 1'b0;
    assign w_unused  = ^{rel, offset};
`endif

    assign w_full  = (r_depth == DepthMax);
    assign w_empty = (r_depth == '0);

    always_comb begin
        w_out_nxt   = r_out;
        w_depth_nxt = r_depth;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_push      = 1'b0;
        if (load) begin
            w_out_nxt = load_value;
        end else if (call) begin
            if (w_full) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_push      = 1'b1;
                w_out_nxt   = load_value;
                w_depth_nxt = r_depth + DepthOne;
            end
        end else if (ret) begin
            if (w_empty) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_out_nxt   = r_stack[r_depth - DepthOne];
                w_depth_nxt = r_depth - DepthOne;
            end
        end else if (w_rel_req) begin
            // Two's-complement add modulo 2^WIDTH needs no sign extension.
            w_out_nxt = r_out + offset;
        end else if (dec) begin
            w_out_nxt = r_out - One;
        end else if (inc) begin
            w_out_nxt = r_out + One;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out   <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_out   <= w_out_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Storage is not reset; entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_depth] <= r_out + One;
        end
    end

    assign out         = r_out;
    assign depth       = r_depth;
    assign stack_full  = w_full;
    assign stack_empty = w_empty;
    assign ovf         = r_ovf;
    assign unf         = r_unf;

endmodule

// File: tb/tb_program_counter_stack.sv
// Randomized self-checking bench for program_counter_stack (WIDTH=8, DEPTH=4)
// against a queue-based reference model.
module tb_program_counter_stack;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset_n;
    logic             load, call, ret, rel, inc, dec;
    logic [WIDTH-1:0] load_value, offset;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             stack_full, stack_empty, ovf, unf;

    program_counter_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_value (load_value),
        .call       (call),
        .ret        (ret),
        .rel        (rel),
        .offset     (offset),
        .inc        (inc),
        .dec        (dec),
        .out        (out),
        .depth      (depth),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .ovf        (ovf),
        .unf        (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain integers and a queue as the stack.
    int m_out;
    int m_stack[$];
    bit m_ovf, m_unf;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, out, m_out);
        check({tag, ".depth"}, depth, m_stack.size());
        check({tag, ".full"}, stack_full, m_stack.size() == DEPTH);
        check({tag, ".empty"}, stack_empty, m_stack.size() == 0);
        check({tag, ".ovf"}, ovf, m_ovf);
        check({tag, ".unf"}, unf, m_unf);
    endtask

    task automatic model_cycle(input bit l, c, r, rl, d, i, input int lv, off);
        int so;
        if (l) begin
            m_out = lv;
        end else if (c) begin
            if (m_stack.size() == DEPTH) m_ovf = 1;
            else begin
                m_stack.push_back((m_out + 1) % 256);
                m_out = lv;
            end
        end else if (r) begin
            if (m_stack.size() == 0) m_unf = 1;
            else m_out = m_stack.pop_back();
`ifdef PC_REL_BRANCH_EN
        end else if (rl) begin
            so    = (off >= 128) ? off - 256 : off;
            m_out = ((m_out + so) % 256 + 256) % 256;
`endif
        end else if (d) begin
            m_out = (m_out + 255) % 256;
        end else if (i) begin
            m_out = (m_out + 1) % 256;
        end
    endtask

    task automatic step(input string tag, input bit l, c, r, rl, d, i,
                        input logic [7:0] lv, input logic [7:0] off);
        load = l; call = c; ret = r; rel = rl; dec = d; inc = i;
        load_value = lv; offset = off;
        @(posedge clk);
        model_cycle(l, c, r, rl, d, i, int'(lv), int'(off));
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #2;
        m_out = 0; m_stack.delete(); m_ovf = 0; m_unf = 0;
        check_all(tag);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        load = 0; call = 0; ret = 0; rel = 0; inc = 0; dec = 0;
        load_value = '0; offset = '0;
        do_reset("rst0");

        // inc x3, dec x4
        for (int k = 0; k < 3; k++) step("inc", 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        check("inc3_out", out, 3);
        for (int k = 0; k < 4; k++) step("dec", 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
        check("dec4_wrap", out, 255);

        // load beats call and inc
        step("prio", 1, 1, 0, 0, 0, 1, 8'h40, 8'h00);
        check("prio_out", out, 8'h40);
        check("prio_depth", depth, 0);

        // nested call/return
        step("ld10", 1, 0, 0, 0, 0, 0, 8'h10, 8'h00);
        step("call80", 0, 1, 0, 0, 0, 0, 8'h80, 8'h00);
        step("call90", 0, 1, 0, 0, 0, 0, 8'h90, 8'h00);
        check("nest_depth", depth, 2);
        check("nest_out", out, 8'h90);
        step("ret1", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        check("ret1_out", out, 8'h81);
        step("ret2", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        check("ret2_out", out, 8'h11);
        check("ret2_empty", stack_empty, 1);

        // overflow and underflow
        do_reset("rst1");
        for (int k = 1; k <= 5; k++) step("ovcall", 0, 1, 0, 0, 0, 0, 8'(k), 8'h00);
        check("ov_depth", depth, 4);
        check("ov_full", stack_full, 1);
        check("ov_flag", ovf, 1);
        check("ov_out", out, 4);
        for (int k = 0; k < 4; k++) step("unret", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        step("unret_empty", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        check("un_flag", unf, 1);
        check("un_out", out, 1);
        check("ov_sticky", ovf, 1);

        // relative branch vs. inc
        step("ld05", 1, 0, 0, 0, 0, 0, 8'h05, 8'h00);
        step("rel", 0, 0, 0, 1, 0, 1, 8'h00, 8'hFA);
`ifdef PC_REL_BRANCH_EN
        check("rel_out", out, 8'hFF);
`else
        check("rel_off_out", out, 8'h06);
`endif

        // asynchronous reset during nested calls
        do_reset("rst2");
        step("rc1", 0, 1, 0, 0, 0, 0, 8'h20, 8'h00);
        step("rc2", 0, 1, 0, 0, 0, 0, 8'h30, 8'h00);
        do_reset("midrst");
        check("midrst_out", out, 0);
        check("midrst_depth", depth, 0);
        step("midrst_ret", 0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        check("midrst_unf", unf, 1);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rrst");
            end else begin
                step("rand",
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 0,
                     8'($urandom), 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
